branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 146 ++++++++++++++
 tb/tb_branch_resolve.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch resolution unit: in-order queue of predicted branches, misprediction
// detection, redirect and timed flush. Optional statistics via BR_STATS_EN.
module branch_resolve #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pred_valid,
    input  logic        pred_taken,
    input  logic [15:0] pred_pc_next,
    input  logic [15:0] pred_target,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [15:0] res_target,
    output logic        stall_fetch,
    output logic        flush,
    output logic        redirect_valid,
    output logic [15:0] redirect_pc,
    output logic        proto_err,
    output logic [15:0] resolved_cnt,
    output logic [15:0] mispred_cnt,
    output logic        fsm_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    // Handshake: pred_valid is accepted in IDLE when the queue has room or the
    // head dequeues in the same cycle; stall_fetch tells fetch to hold.
    state_t          state, state_nxt;
    logic [2:0]      flush_cnt;
    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_ptr, rd_ptr;

    logic            q_taken   [DEPTH];
    logic [15:0]     q_pc_next [DEPTH];
    logic [15:0]     q_target  [DEPTH];

    logic            idle, full, empty, deq, enq, mispred, flush_done;
    logic            head_taken;
    logic [15:0]     head_pc_next, head_target, correct_pc;

    always_comb begin
        head_taken   = q_taken[rd_ptr];
        head_pc_next = q_pc_next[rd_ptr];
        head_target  = q_target[rd_ptr];
        idle         = (state == IDLE);
        full         = (count == CW'(DEPTH));
        empty        = (count == '0);
        deq          = idle & res_valid & ~empty;
        // A taken branch is only correct if the predicted target also matched
        mispred      = deq & ((res_taken != head_taken) |
                              (res_taken & (res_target != head_target)));
        enq          = idle & pred_valid & (~full | deq) & ~mispred;
        correct_pc   = res_taken ? res_target : head_pc_next;
        flush_done   = (flush_cnt == 3'(FLUSH_CYCLES));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mispred) state_nxt = FLUSH;
            FLUSH:   if (flush_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (mispred)
                flush_cnt <= 3'd1;
            else if (state == FLUSH && !flush_done)
                flush_cnt <= flush_cnt + 3'd1;
            else
                flush_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (mispred) begin
            // Everything younger than the mispredicted branch is wrong-path
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_taken[wr_ptr]   <= pred_taken;
            q_pc_next[wr_ptr] <= pred_pc_next;
            q_target[wr_ptr]  <= pred_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 16'h0000;
            proto_err      <= 1'b0;
        end else begin
            redirect_valid <= mispred;
            if (mispred) redirect_pc <= correct_pc;
            if (idle && res_valid && empty) proto_err <= 1'b1;
        end
    end

    assign stall_fetch = full;
    assign flush       = (state == FLUSH);
    assign fsm_state   = (state == FLUSH);

`ifdef BR_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resolved_cnt <= 16'h0000;
            mispred_cnt  <= 16'h0000;
        end else begin
            if (deq && resolved_cnt != 16'hFFFF) resolved_cnt <= resolved_cnt + 16'd1;
            if (mispred && mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
        end
    end
`else
    assign resolved_cnt = 16'h0000;
    assign mispred_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: queue fill/stall, correct and wrong
// predictions, flush timing, protocol error, async reset and statistics.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        reset;
    logic        pred_valid, pred_taken, res_valid, res_taken;
    logic [15:0] pred_pc_next, pred_target, res_target;
    logic        stall_fetch, flush, redirect_valid, proto_err, fsm_state;
    logic [15:0] redirect_pc, resolved_cnt, mispred_cnt;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    branch_resolve #(.DEPTH(4), .FLUSH_CYCLES(3)) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_pc_next(pred_pc_next), .pred_target(pred_target),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .stall_fetch(stall_fetch), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .proto_err(proto_err), .resolved_cnt(resolved_cnt),
        .mispred_cnt(mispred_cnt), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic pv, input logic pt, input logic [15:0] pcn,
                         input logic [15:0] ptg, input logic rv, input logic rt,
                         input logic [15:0] rtg);
        pred_valid = pv; pred_taken = pt; pred_pc_next = pcn; pred_target = ptg;
        res_valid = rv; res_taken = rt; res_target = rtg;
        @(posedge clk); #1;
        pred_valid = 1'b0; res_valid = 1'b0;
    endtask

    task automatic enqueue(input logic pt, input logic [15:0] pcn, input logic [15:0] ptg);
        cycle(1'b1, pt, pcn, ptg, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic resolve(input logic rt, input logic [15:0] rtg);
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, rt, rtg);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic check_redirect_pulse(input string tag);
        check({tag, "_rv"}, 16'(redirect_valid), 16'd1);
        check({tag, "_pc"}, redirect_pc, exp_q.pop_front());
        check({tag, "_flush"}, 16'(flush), 16'd1);
    endtask

    initial begin
        reset = 1'b1;
        pred_valid = 1'b0; pred_taken = 1'b0; pred_pc_next = '0; pred_target = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 16'(stall_fetch), 16'd0);
        check("rst_flush", 16'(flush), 16'd0);
        check("rst_rv", 16'(redirect_valid), 16'd0);
        check("rst_pc", redirect_pc, 16'h0000);
        check("rst_perr", 16'(proto_err), 16'd0);
        check("rst_count", 16'(dut.count), 16'd0);
        check("rst_res_cnt", resolved_cnt, 16'd0);
        check("rst_mis_cnt", mispred_cnt, 16'd0);
        reset = 1'b0;
        idle_cycle();

        // Correct taken prediction: dequeue only
        enqueue(1'b1, 16'h3002, 16'h3010);
        check("c_count1", 16'(dut.count), 16'd1);
        resolve(1'b1, 16'h3010);
        check("c_count0", 16'(dut.count), 16'd0);
        check("c_flush", 16'(flush), 16'd0);
        check("c_rv", 16'(redirect_valid), 16'd0);

        // Predicted taken, actually not taken: redirect to fall-through
        enqueue(1'b1, 16'h3002, 16'h3010);
        exp_q.push_back(16'h3002);
        resolve(1'b0, 16'h3010);
        check_redirect_pulse("m1");
        idle_cycle();
        check("m1_rv_n2", 16'(redirect_valid), 16'd0);
        check("m1_flush_n2", 16'(flush), 16'd1);
        idle_cycle();
        check("m1_flush_n3", 16'(flush), 16'd1);
        idle_cycle();
        check("m1_flush_n4", 16'(flush), 16'd0);
        check("m1_pc_hold", redirect_pc, 16'h3002);

        // Fill to DEPTH, drop when full, accept with concurrent dequeue
        for (int i = 0; i < 4; i++) enqueue(1'b0, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
        check("f_stall", 16'(stall_fetch), 16'd1);
        check("f_count4", 16'(dut.count), 16'd4);
        enqueue(1'b1, 16'h1004, 16'h2004);
        check("f_drop_count", 16'(dut.count), 16'd4);
        cycle(1'b1, 1'b1, 16'h1005, 16'h2005, 1'b1, 1'b0, 16'hdead);
        check("f_accept_count", 16'(dut.count), 16'd4);
        check("f_accept_rv", 16'(redirect_valid), 16'd0);
        for (int i = 0; i < 3; i++) begin
            resolve(1'b0, 16'hbeef);
            check("f_drain_rv", 16'(redirect_valid), 16'd0);
        end
        check("f_stall_clear", 16'(stall_fetch), 16'd0);
        resolve(1'b1, 16'h2005);
        check("f_last_rv", 16'(redirect_valid), 16'd0);
        check("f_last_count", 16'(dut.count), 16'd0);

        // Wrong target with three queued; everything is squashed
        enqueue(1'b1, 16'h4002, 16'h4100);
        enqueue(1'b1, 16'h4006, 16'h4200);
        enqueue(1'b1, 16'h400a, 16'h4300);
        check("w_count3", 16'(dut.count), 16'd3);
        exp_q.push_back(16'h4180);
        resolve(1'b1, 16'h4180);
        check_redirect_pulse("m2");
        check("w_count0", 16'(dut.count), 16'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 16'h5000, 16'h5100, 1'b1, 1'b0, 16'h0);
        end
        check("w_flush_end", 16'(flush), 16'd0);
        check("w_ignored_count", 16'(dut.count), 16'd0);
        check("w_ignored_perr", 16'(proto_err), 16'd0);
        check("w_ignored_rv", 16'(redirect_valid), 16'd0);

        // Not-taken correct (target ignored), then not-taken mispredicted
        enqueue(1'b0, 16'h5002, 16'h5040);
        resolve(1'b0, 16'h1234);
        check("n_rv", 16'(redirect_valid), 16'd0);
        enqueue(1'b0, 16'h5002, 16'h5040);
        exp_q.push_back(16'h5040);
        resolve(1'b1, 16'h5040);
        check_redirect_pulse("m3");
        repeat (3) idle_cycle();
        check("n_flush_end", 16'(flush), 16'd0);
`ifdef BR_STATS_EN
        check("s_resolved", resolved_cnt, 16'd10);
        check("s_mispred", mispred_cnt, 16'd3);
`else
        check("s_resolved", resolved_cnt, 16'd0);
        check("s_mispred", mispred_cnt, 16'd0);
`endif

        // Resolution with an empty queue is a protocol error, sticky
        resolve(1'b1, 16'h0042);
        check("p_perr", 16'(proto_err), 16'd1);
        check("p_rv", 16'(redirect_valid), 16'd0);
        check("p_count", 16'(dut.count), 16'd0);
        repeat (2) idle_cycle();
        check("p_perr_hold", 16'(proto_err), 16'd1);

        // Async reset in the middle of a flush
        enqueue(1'b1, 16'h6002, 16'h6100);
        enqueue(1'b0, 16'h6006, 16'h6200);
        exp_q.push_back(16'h6002);
        resolve(1'b0, 16'h0);
        check_redirect_pulse("m4");
        reset = 1'b1;
        #1;
        check("r_flush", 16'(flush), 16'd0);
        check("r_rv", 16'(redirect_valid), 16'd0);
        check("r_perr", 16'(proto_err), 16'd0);
        check("r_pc", redirect_pc, 16'h0000);
        check("r_count", 16'(dut.count), 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycle();
        check("r_post_state", 16'(fsm_state), 16'd0);
        check("r_post_stall", 16'(stall_fetch), 16'd0);
        check("r_post_res_cnt", resolved_cnt, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
